ysyx_22040632_divider: RTL and testbench
========================================

Name: ysyx_22040632_divider

Overview:
- Sequential radix-2 restoring integer divider for the ALU extension; the inverse companion to the Booth multiplier datapath.
- Executes RV64M DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW.
- Produces quotient and remainder together, one bit per cycle.
- Sits beside the multiplier in alu_ext, with a valid/ready request and a valid/ready response toward the EXU.

Parameters:
WIDTH, 64, operand/result width in bits; also the iteration count.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  synchronous reset, active low.
div_valid  input  1  request valid.
div_ready  output  1  divider can accept a request (high only in IDLE).
dividend  input  WIDTH  rs1 value.
divisor  input  WIDTH  rs2 value.
div_signed  input  1  1 = signed (DIV/REM), 0 = unsigned.
div_word  input  1  1 = W-variant; only low 32 bits of the operands are used.
flush  input  1  kill the in-flight operation (pipeline redirect).
out_valid  output  1  result valid.
out_ready  input  1  consumer takes the result.
quotient  output  WIDTH  quotient.
remainder  output  WIDTH  remainder.

Behaviour:
- Reset (rst_n=0 sampled at a rising clk edge): state=IDLE, div_ready=1, out_valid=0, quotient=0, remainder=0, all internal registers 0.
- Reset has priority over flush and over every handshake.
- States: IDLE, CALC, DONE.
- IDLE:
  - div_ready=1.
  - On div_valid&&div_ready (accept edge), latch the prepared operands, sign flags and word flag.
  - If divisor==0 or signed overflow, go to DONE with the special result loaded. Otherwise load counter=WIDTH, partial remainder=0, shift register=|dividend|, and go to CALC.
- Operand prep at accept:
  - Word mode: the low 32 bits are sign-extended (signed) or zero-extended (unsigned) to WIDTH.
  - Signed: use absolute values.
  - Record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
- CALC, each cycle:
  - Shift {rem, q} left by 1.
  - Trial = rem - |divisor|, computed WIDTH+1 bits wide.
  - If the trial is non-negative, rem = trial and q[0]=1; else q[0]=0.
  - Decrement counter; when the counter reaches 1, the next state is DONE.
  - Exactly WIDTH CALC cycles.
- Result fix-up on entry to DONE:
  - Negate q if neg_q; negate rem if neg_r.
  - Word mode: sign-extend both results from bit 31 (signed and unsigned alike).
- Special results, bypassing CALC (checked on the word-extended operands):
  - Divide by zero: quotient = all ones, remainder = dividend (word mode: each sign-extended from bit 31).
  - Signed overflow (most-negative / -1): quotient = dividend, remainder = 0. In word mode the most-negative value is -2^31.
- DONE:
  - out_valid=1; quotient and remainder are held stable until out_valid&&out_ready.
  - On that handshake go to IDLE; out_valid drops the next cycle.
  - No new request is accepted in the same cycle as the result handshake (div_ready=0 in DONE).
- Latency, counted from the accept edge to the first cycle with out_valid=1:
  - normal: WIDTH+1 cycles;
  - special case: 1 cycle.
- flush:
  - In CALC or DONE: go to IDLE at the next edge, out_valid=0, and the result is discarded.
  - In IDLE: a request presented in the same cycle is not accepted.
  - Flush in DONE overrides a simultaneous out_ready.
- quotient and remainder hold their last values in IDLE; they are meaningful only while out_valid=1.
- div_valid while busy is ignored; the requester must hold the request until div_ready.

Test Plan:
- Unsigned 64-bit: dividend=100, divisor=7 -> quotient=14, remainder=2; out_valid exactly 65 cycles after the accept edge.
- Signed: dividend=-7 (0xFFFF_FFFF_FFFF_FFF9), divisor=2 -> quotient=0xFFFF_FFFF_FFFF_FFFD (-3), remainder=0xFFFF_FFFF_FFFF_FFFF (-1).
- Divide by zero, signed, dividend=0x1234 -> quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0x1234, out_valid 1 cycle after accept. Overflow case: dividend=0x8000_0000_0000_0000, divisor=-1 -> quotient=0x8000_0000_0000_0000, remainder=0.
- Word mode:
  - DIVUW with dividend=0xDEAD_0000_8000_0000, divisor=2 -> quotient=0x0000_0000_4000_0000, remainder=0.
  - DIVW with dividend=0x0000_0000_8000_0000, divisor=0x0000_0000_FFFF_FFFF -> overflow path, quotient=0xFFFF_FFFF_8000_0000, remainder=0.
- Backpressure and flush:
  - Hold out_ready=0 for 10 cycles after out_valid: outputs stay stable and div_ready=0.
  - Separate run: assert flush 20 cycles into CALC -> IDLE the next cycle with out_valid never asserted; a following request 100/7 still returns 14/2.
- Reset mid-operation: drive rst_n=0 for one edge during CALC -> div_ready=1, out_valid=0, quotient=remainder=0 the following cycle.

Source files
------------

// File: rtl/ysyx_22040632_divider.sv
// Sequential radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W variants.
// One quotient bit per cycle; divide-by-zero and signed overflow skip the iteration loop.
module ysyx_22040632_divider #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             div_signed,
    input  logic             div_word,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_D = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MIN_W = {{(WIDTH-31){1'b1}}, {31{1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             word_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;

    function automatic logic [WIDTH-1:0] sext_word(input logic [WIDTH-1:0] v);
        return {{(WIDTH-32){v[31]}}, v[31:0]};
    endfunction

    // Operand preparation at the accept edge
    logic [WIDTH-1:0] a_ext, b_ext, a_abs, b_abs;
    logic             a_neg, b_neg, div_zero, overflow, special, accept;

    always_comb begin
        if (div_word) begin
            a_ext = div_signed ? sext_word(dividend) : {{(WIDTH-32){1'b0}}, dividend[31:0]};
            b_ext = div_signed ? sext_word(divisor)  : {{(WIDTH-32){1'b0}}, divisor[31:0]};
        end else begin
            a_ext = dividend;
            b_ext = divisor;
        end
        a_neg    = div_signed & a_ext[WIDTH-1];
        b_neg    = div_signed & b_ext[WIDTH-1];
        a_abs    = a_neg ? -a_ext : a_ext;
        b_abs    = b_neg ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        overflow = div_signed && (b_ext == '1) && (a_ext == (div_word ? MIN_W : MIN_D));
        special  = div_zero | overflow;
        accept   = div_valid && (state_reg == IDLE) && !flush;
    end

    // One restoring step; the trial is one bit wider so its MSB is the borrow
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_step, q_step, q_fix, r_fix;

    always_comb begin
        trial    = {rem_reg, q_reg[WIDTH-1]} - {1'b0, dvs_reg};
        rem_step = trial[WIDTH] ? {rem_reg[WIDTH-2:0], q_reg[WIDTH-1]} : trial[WIDTH-1:0];
        q_step   = {q_reg[WIDTH-2:0], ~trial[WIDTH]};
        q_fix    = neg_q_reg ? -q_step : q_step;
        r_fix    = neg_r_reg ? -rem_step : rem_step;
        if (word_reg) begin
            q_fix = sext_word(q_fix);
            r_fix = sext_word(r_fix);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = special ? DONE : CALC;
            CALC: begin
                if (flush)              state_next = IDLE;
                else if (cnt_reg == 1)  state_next = DONE;
            end
            DONE: if (flush || out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            rem_reg       <= '0;
            q_reg         <= '0;
            dvs_reg       <= '0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            word_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        neg_q_reg <= a_neg ^ b_neg;
                        neg_r_reg <= a_neg;
                        word_reg  <= div_word;
                        dvs_reg   <= b_abs;
                        if (div_zero) begin
                            quotient_reg  <= '1;
                            remainder_reg <= div_word ? sext_word(a_ext) : a_ext;
                        end else if (overflow) begin
                            quotient_reg  <= div_word ? sext_word(a_ext) : a_ext;
                            remainder_reg <= '0;
                        end else begin
                            cnt_reg <= CW'(WIDTH);
                            rem_reg <= '0;
                            q_reg   <= a_abs;
                        end
                    end
                end
                CALC: begin
                    if (!flush) begin
                        rem_reg <= rem_step;
                        q_reg   <= q_step;
                        cnt_reg <= cnt_reg - CW'(1);
                        if (cnt_reg == 1) begin
                            quotient_reg  <= q_fix;
                            remainder_reg <= r_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_ready = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;

endmodule

// File: tb/tb_ysyx_22040632_divider.sv
// Self-checking bench: directed RV64M cases plus randomized requests against an arithmetic model.
module tb_ysyx_22040632_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        div_valid = 1'b0;
    logic        div_ready;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic        div_signed = 1'b0;
    logic        div_word = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] quotient;
    logic [63:0] remainder;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [63:0] exp_q = '0;
    logic [63:0] exp_r = '0;
    logic        exp_active = 1'b0;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    ysyx_22040632_divider #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .div_signed(div_signed),
        .div_word  (div_word),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total_cnt++;
        if (act !== expv)
            $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, expv, $time);
        else
            pass_cnt++;
    endtask

    // RISC-V division semantics in plain arithmetic
    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w,
                         output logic [63:0] q, output logic [63:0] r);
        logic [31:0] a32, b32, q32, r32;
        int          sa, sb;
        longint      la, lb;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 0) begin
                q32 = 32'hFFFF_FFFF; r32 = a32;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 32'h0;
            end else if (s) begin
                sa = a32; sb = b32;
                q32 = 32'(sa / sb); r32 = 32'(sa % sb);
            end else begin
                q32 = a32 / b32; r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 0) begin
                q = '1; r = a;
            end else if (s && a == MIN64 && b == '1) begin
                q = a; r = '0;
            end else if (s) begin
                la = a; lb = b;
                q = 64'(la / lb); r = 64'(la % lb);
            end else begin
                q = a / b; r = a % b;
            end
        end
    endtask

    function automatic bit is_special(input logic [63:0] a, input logic [63:0] b,
                                      input logic s, input logic w);
        if (w) return (b[31:0] == 0) || (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 0) || (s && a == MIN64 && b == '1);
    endfunction

    // Output checker: every cycle with out_valid the result must match the model
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!exp_active) begin
                chk("unexpected_valid", 64'(out_valid), 64'd0);
            end else begin
                chk("quotient", quotient, exp_q);
                chk("remainder", remainder, exp_r);
                chk("ready_in_done", 64'(div_ready), 64'd0);
            end
        end
    end

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                          input logic w, input int hold);
        logic [63:0] mq, mr;
        int          n, exp_lat;
        model(a, b, s, w, mq, mr);
        exp_lat = is_special(a, b, s, w) ? 1 : 65;
        dividend = a; divisor = b; div_signed = s; div_word = w; div_valid = 1'b1;
        @(posedge clk); #1;
        div_valid = 1'b0;
        exp_q = mq; exp_r = mr; exp_active = 1'b1;
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(exp_lat));
        $display("op a=%h b=%h s=%0d w=%0d -> q=%h r=%h lat=%0d", a, b, s, w, quotient, remainder, n);
        if (out_valid) begin
            repeat (hold) @(posedge clk);
            #1 out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            exp_active = 1'b0;
            chk("valid_drop", 64'(out_valid), 64'd0);
            chk("ready_back", 64'(div_ready), 64'd1);
        end
        exp_active = 1'b0;
    endtask

    logic [63:0] mq, mr, ra, rb;
    int          sel;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(div_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_q", quotient, 64'd0);
        chk("rst_r", remainder, 64'd0);
        rst_n = 1'b1;

        // Pin the model with hand-computed values
        model(64'd100, 64'd7, 1'b0, 1'b0, mq, mr);
        chk("model_100_7_q", mq, 64'd14); chk("model_100_7_r", mr, 64'd2);
        model(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, mq, mr);
        chk("model_m7_2_q", mq, 64'hFFFF_FFFF_FFFF_FFFD); chk("model_m7_2_r", mr, 64'hFFFF_FFFF_FFFF_FFFF);
        model(64'h1234, 64'd0, 1'b1, 1'b0, mq, mr);
        chk("model_dz_q", mq, 64'hFFFF_FFFF_FFFF_FFFF); chk("model_dz_r", mr, 64'h1234);
        model(MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, mq, mr);
        chk("model_ovf_q", mq, MIN64); chk("model_ovf_r", mr, 64'd0);
        model(64'hDEAD_0000_8000_0000, 64'd2, 1'b0, 1'b1, mq, mr);
        chk("model_divuw_q", mq, 64'h0000_0000_4000_0000); chk("model_divuw_r", mr, 64'd0);
        model(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, mq, mr);
        chk("model_divw_q", mq, 64'hFFFF_FFFF_8000_0000); chk("model_divw_r", mr, 64'd0);

        // Directed cases; the 100/7 run also exercises 10 cycles of backpressure
        run_op(64'd100, 64'd7, 1'b0, 1'b0, 10);
        run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 0);
        run_op(64'h1234, 64'd0, 1'b1, 1'b0, 2);
        run_op(MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0);
        run_op(64'hDEAD_0000_8000_0000, 64'd2, 1'b0, 1'b1, 0);
        run_op(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 1);

        // Flush in IDLE blocks acceptance
        dividend = 64'd100; divisor = 64'd7; div_signed = 1'b0; div_word = 1'b0;
        div_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        div_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_no_accept", 64'(div_ready), 64'd1);

        // Flush 20 cycles into CALC
        div_valid = 1'b1;
        @(posedge clk); #1;
        div_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_ready", 64'(div_ready), 64'd1);
        chk("flush_valid", 64'(out_valid), 64'd0);
        repeat (70) @(posedge clk);
        #1;
        run_op(64'd100, 64'd7, 1'b0, 1'b0, 0);

        // Reset mid-operation
        dividend = 64'd12345; divisor = 64'd17; div_valid = 1'b1;
        @(posedge clk); #1;
        div_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_ready", 64'(div_ready), 64'd1);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_q", quotient, 64'd0);
        chk("midrst_r", remainder, 64'd0);

        // Randomized requests with biased corner operands
        for (int i = 0; i < 150; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom} >> $urandom_range(0, 63);
            sel = $urandom_range(0, 7);
            case (sel)
                0: rb = '0;
                1: rb = '1;
                2: begin ra = ($urandom_range(0, 1) != 0) ? MIN64 : 64'hFFFF_FFFF_8000_0000; rb = '1; end
                3: rb = 64'($urandom_range(1, 15));
                4: ra = 64'($urandom_range(0, 1000));
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
